// File: rtl/pulse_stretch_if.sv
// Event-in / level-out signal bundle for pulse_stretch.
// Defining PULSE_STRETCH_ACK_EN adds the ACK input.
interface pulse_stretch_if #(
    parameter int CNT_W  = 8,
    parameter int PEND_W = 2
);
    logic              PULSE_IN;
    logic [CNT_W-1:0]  LEN;
    logic              CLR_OVF;
`ifdef PULSE_STRETCH_ACK_EN
    logic              ACK;
`endif
    logic              LVL_OUT;
    logic              BUSY;
    logic [PEND_W-1:0] PEND_CNT;
    logic              OVF;

`ifdef PULSE_STRETCH_ACK_EN
    modport master (output PULSE_IN, LEN, CLR_OVF, ACK,
                    input  LVL_OUT, BUSY, PEND_CNT, OVF);
    modport slave  (input  PULSE_IN, LEN, CLR_OVF, ACK,
                    output LVL_OUT, BUSY, PEND_CNT, OVF);
`else
    modport master (output PULSE_IN, LEN, CLR_OVF,
                    input  LVL_OUT, BUSY, PEND_CNT, OVF);
    modport slave  (input  PULSE_IN, LEN, CLR_OVF,
                    output LVL_OUT, BUSY, PEND_CNT, OVF);
`endif
endinterface

// File: rtl/pulse_stretch.sv
// Stretches single-cycle events into levels of LEN cycles separated by GAP_CYC low cycles,
// queueing overlapping events. Define PULSE_STRETCH_ACK_EN to make HOLD also wait for ACK.
//
// state | meaning
// IDLE  | no level active, queue empty
// HOLD  | LVL_OUT high, hold counter running down to 1
// GAP   | LVL_OUT forced low, gap counter running down to 1
module pulse_stretch #(
    parameter int CNT_W   = 8,
    parameter int GAP_CYC = 1,
    parameter int PEND_W  = 2
) (
    input logic            CLK,
    input logic            RST,
    pulse_stretch_if.slave bus
);
    localparam int GAP_W = $clog2(GAP_CYC + 1);
    localparam logic [PEND_W-1:0] PEND_MAX = '1;

    typedef enum logic [1:0] {IDLE, HOLD, GAP} state_t;

    state_t            state_q, state_nxt;
    logic [CNT_W-1:0]  hold_cnt, hold_nxt, len_eff;
    logic [GAP_W-1:0]  gap_cnt, gap_nxt;
    logic [PEND_W-1:0] pend_q, pend_nxt;
    logic              ovf_q, ovf_nxt;
    logic              lvl_q, busy_q;
    logic              start, queue, drop, hold_done;

    assign len_eff = (bus.LEN == '0) ? CNT_W'(1) : bus.LEN;

`ifdef PULSE_STRETCH_ACK_EN
    logic ack_seen, ack_nxt;
    assign hold_done = (hold_cnt == CNT_W'(1)) && (ack_seen || bus.ACK);
`else
    assign hold_done = (hold_cnt == CNT_W'(1));
`endif

    always_comb begin
        state_nxt = state_q;
        hold_nxt  = hold_cnt;
        gap_nxt   = gap_cnt;
        pend_nxt  = pend_q;
        start     = 1'b0;
        queue     = 1'b0;
        drop      = 1'b0;
`ifdef PULSE_STRETCH_ACK_EN
        ack_nxt   = ack_seen;
`endif
        case (state_q)
            IDLE: begin
                if (bus.PULSE_IN) start = 1'b1;
            end
            HOLD: begin
                queue = bus.PULSE_IN;
`ifdef PULSE_STRETCH_ACK_EN
                ack_nxt = ack_seen | bus.ACK;
`endif
                if (hold_done) begin
                    state_nxt = GAP;
                    gap_nxt   = GAP_W'(GAP_CYC);
                end else if (hold_cnt != CNT_W'(1)) begin
                    hold_nxt = hold_cnt - CNT_W'(1);
                end
            end
            GAP: begin
                if (gap_cnt == GAP_W'(1)) begin
                    // An event arriving on the dequeue cycle replaces the one being dequeued.
                    if (pend_q != '0 || bus.PULSE_IN) begin
                        start = 1'b1;
                        if (!bus.PULSE_IN) pend_nxt = pend_q - PEND_W'(1);
                    end else begin
                        state_nxt = IDLE;
                    end
                end else begin
                    gap_nxt = gap_cnt - GAP_W'(1);
                    queue   = bus.PULSE_IN;
                end
            end
            default: state_nxt = IDLE;
        endcase

        if (queue) begin
            if (pend_q == PEND_MAX) drop = 1'b1;
            else                    pend_nxt = pend_q + PEND_W'(1);
        end

        if (start) begin
            state_nxt = HOLD;
            hold_nxt  = len_eff;
`ifdef PULSE_STRETCH_ACK_EN
            ack_nxt   = 1'b0;
`endif
        end

        if (drop)             ovf_nxt = 1'b1;
        else if (bus.CLR_OVF) ovf_nxt = 1'b0;
        else                  ovf_nxt = ovf_q;
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q  <= IDLE;
            hold_cnt <= '0;
            gap_cnt  <= '0;
            pend_q   <= '0;
            ovf_q    <= 1'b0;
            lvl_q    <= 1'b0;
            busy_q   <= 1'b0;
`ifdef PULSE_STRETCH_ACK_EN
            ack_seen <= 1'b0;
`endif
        end else begin
            state_q  <= state_nxt;
            hold_cnt <= hold_nxt;
            gap_cnt  <= gap_nxt;
            pend_q   <= pend_nxt;
            ovf_q    <= ovf_nxt;
            lvl_q    <= (state_nxt == HOLD);
            busy_q   <= (state_nxt != IDLE);
`ifdef PULSE_STRETCH_ACK_EN
            ack_seen <= ack_nxt;
`endif
        end
    end

    assign bus.LVL_OUT  = lvl_q;
    assign bus.BUSY     = busy_q;
    assign bus.PEND_CNT = pend_q;
    assign bus.OVF      = ovf_q;
endmodule
